// File: rtl/fdt16_pkg.sv
// fdt16_pkg -- shared widths, channel count and types for the result demux slice.
// Rev 1.0
`default_nettype none

package fdt16_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int N_CHAN     = 4;

  typedef logic [1:0] chan_sel_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

`default_nettype wire

// File: rtl/chan_slot.sv
// chan_slot -- one-entry output slot: loads a routed word, holds it until drained.
// Rev 1.0
`default_nettype none

module chan_slot
  import fdt16_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  slot_state_t       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // A load while full is only offered when the consumer drains the same cycle,
  // so the slot stays full and simply takes the new word.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (load_i) begin
          state_d = SLOT_FULL;
          data_d  = data_i;
        end
      end
      SLOT_FULL: begin
        if (load_i) begin
          data_d = data_i;
        end else if (ready_i) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/result_demux.sv
// result_demux -- routes one input word per cycle into one of four independent one-entry slots.
// Rev 1.0
`default_nettype none

module result_demux
  import fdt16_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_OUT  = N_CHAN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  chan_sel_t         in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic              out_valid0,
  output logic              out_valid1,
  output logic              out_valid2,
  output logic              out_valid3,
  input  logic              out_ready0,
  input  logic              out_ready1,
  input  logic              out_ready2,
  input  logic              out_ready3,
  output logic [15:0]       xfer_count,
  output logic              busy
);

  logic [N_OUT-1:0]  slot_valid;
  logic [N_OUT-1:0]  slot_ready;
  logic [N_OUT-1:0]  slot_load;
  logic [DATA_W-1:0] slot_data [N_OUT];
  logic              in_xfer;
  logic [15:0]       xfer_count_q, xfer_count_d;

  assign slot_ready = {out_ready3, out_ready2, out_ready1, out_ready0};

  // Ready looks only at the addressed slot, so one stalled consumer never blocks the others.
  assign in_ready = ~slot_valid[in_sel] | slot_ready[in_sel];
  assign in_xfer  = in_valid & in_ready;

  for (genvar n = 0; n < N_OUT; n++) begin : g_chan
    assign slot_load[n] = in_xfer & (in_sel == chan_sel_t'(n));

    chan_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (slot_load[n]),
      .data_i  (in_data),
      .ready_i (slot_ready[n]),
      .valid_o (slot_valid[n]),
      .data_o  (slot_data[n])
    );
  end

  assign xfer_count_d = in_xfer ? xfer_count_q + 16'd1 : xfer_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count_q <= '0;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign out_data0  = slot_data[0];
  assign out_data1  = slot_data[1];
  assign out_data2  = slot_data[2];
  assign out_data3  = slot_data[3];
  assign out_valid0 = slot_valid[0];
  assign out_valid1 = slot_valid[1];
  assign out_valid2 = slot_valid[2];
  assign out_valid3 = slot_valid[3];
  assign xfer_count = xfer_count_q;
  assign busy       = |slot_valid;

endmodule

`default_nettype wire

// File: tb/tb_result_demux.sv
// tb_result_demux -- scoreboard bench for result_demux with a per-channel queue model.
// Rev 1.0
`default_nettype none

module tb_result_demux;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data0, out_data1, out_data2, out_data3;
  logic          out_valid0, out_valid1, out_valid2, out_valid3;
  logic          out_ready0, out_ready1, out_ready2, out_ready3;
  logic [15:0]   xfer_count;
  logic          busy;

  result_demux #(.DATA_W(DW), .N_OUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data0  (out_data0),
    .out_data1  (out_data1),
    .out_data2  (out_data2),
    .out_data3  (out_data3),
    .out_valid0 (out_valid0),
    .out_valid1 (out_valid1),
    .out_valid2 (out_valid2),
    .out_valid3 (out_valid3),
    .out_ready0 (out_ready0),
    .out_ready1 (out_ready1),
    .out_ready2 (out_ready2),
    .out_ready3 (out_ready3),
    .xfer_count (xfer_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] od [4];
  logic [3:0]    ov;
  logic [3:0]    ordy;
  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;
  assign ov    = {out_valid3, out_valid2, out_valid1, out_valid0};
  assign {out_ready3, out_ready2, out_ready1, out_ready0} = ordy;

  int tests  = 0;
  int errors = 0;

  // Reference model: each channel is a FIFO that may hold at most one word.
  logic [DW-1:0] mq [4][$];
  logic [DW-1:0] last_w [4];
  logic [15:0]   exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      mq[c].delete();
      last_w[c] = '0;
    end
    exp_cnt = '0;
  endtask

  // Monitor: compare what the DUT shows this cycle, then apply this cycle's transfers.
  always @(negedge clk) begin
    if (rst_n) begin
      logic          m_ready;
      logic          any_v;
      logic [3:0]    pop;
      any_v = 1'b0;
      for (int c = 0; c < 4; c++) begin
        logic has;
        has   = (mq[c].size() != 0);
        any_v = any_v | has;
        check($sformatf("valid%0d", c), {31'd0, ov[c]}, {31'd0, has});
        if (has) check($sformatf("data%0d", c), {16'd0, od[c]}, {16'd0, mq[c][0]});
        else     check($sformatf("held%0d", c), {16'd0, od[c]}, {16'd0, last_w[c]});
        if (mq[c].size() > 1) check($sformatf("depth%0d", c), mq[c].size(), 1);
        pop[c] = has & ordy[c];
      end
      check("busy", {31'd0, busy}, {31'd0, any_v});
      check("xfer_count", {16'd0, xfer_count}, {16'd0, exp_cnt});
      m_ready = (mq[in_sel].size() == 0) || ordy[in_sel];
      check("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
      for (int c = 0; c < 4; c++) if (pop[c]) void'(mq[c].pop_front());
      if (in_valid && m_ready) begin
        mq[in_sel].push_back(in_data);
        last_w[in_sel] = in_data;
        exp_cnt = exp_cnt + 16'd1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_state_checks(input string tag);
    check({tag, "_valid"}, {28'd0, ov}, 32'd0);
    check({tag, "_d0"}, {16'd0, out_data0}, 32'd0);
    check({tag, "_d1"}, {16'd0, out_data1}, 32'd0);
    check({tag, "_d2"}, {16'd0, out_data2}, 32'd0);
    check({tag, "_d3"}, {16'd0, out_data3}, 32'd0);
    check({tag, "_cnt"}, {16'd0, xfer_count}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    model_clear();
    rst_n    = 1'b0;
    in_data  = '0;
    in_sel   = '0;
    in_valid = 1'b0;
    ordy     = '0;
    #12;
    reset_state_checks("rst");
    #11 rst_n = 1'b1;
    step();

    // Single routed word lands one cycle later.
    in_data = 16'h1234; in_sel = 2'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("r031_valid", {28'd0, ov}, 32'h4);
    check("r031_data2", {16'd0, out_data2}, 32'h1234);
    check("r031_cnt", {16'd0, xfer_count}, 32'd1);

    // Stalled channel 2 back-pressures only its own inputs.
    in_data = 16'hDEAD; in_sel = 2'd2; in_valid = 1'b1;
    #1 check("r032_stall", {31'd0, in_ready}, 32'd0);
    step();
    check("r032_kept", {16'd0, out_data2}, 32'h1234);
    in_data = 16'hBEEF; in_sel = 2'd0;
    #1 check("r032_other", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("r032_data0", {16'd0, out_data0}, 32'hBEEF);

    // Simultaneous drain and refill of channel 1.
    in_data = 16'hAAAA; in_sel = 2'd1; in_valid = 1'b1;
    step();
    check("r033_first", {16'd0, out_data1}, 32'hAAAA);
    ordy[1] = 1'b1; in_data = 16'h5555;
    #1 check("r033_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0; ordy = '0;
    check("r033_valid", {31'd0, out_valid1}, 32'd1);
    check("r033_data", {16'd0, out_data1}, 32'h5555);

    // Fill channel 3, then an asynchronous reset pulse between edges.
    in_data = 16'h7777; in_sel = 2'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("r035_full", {28'd0, ov}, 32'hF);
    #1 rst_n = 1'b0;
    #1 reset_state_checks("r035");
    model_clear();
    #1 rst_n = 1'b1;

    // Counter wrap: 65535 transfers reach 0xFFFF, one more wraps to zero.
    ordy = 4'b0001; in_sel = 2'd0; in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_data = i[15:0];
      step();
    end
    in_valid = 1'b0;
    check("r034_max", {16'd0, xfer_count}, 32'hFFFF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("r034_wrap", {16'd0, xfer_count}, 32'h0);

    // Randomised traffic; the monitor enforces ordering, no loss and no duplication.
    for (int i = 0; i < 10000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = 2'($urandom_range(0, 3));
      in_data  = 16'($urandom);
      ordy     = 4'($urandom);
      step();
    end
    in_valid = 1'b0;
    ordy     = 4'hF;
    step();
    step();
    check("drain_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/result_demux.md
RESULT_DEMUX -- requirements
Module: result_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the width of the data word.
REQ-002 SHALL have parameter N_OUT, default 4, meaning the number of output channels; it is fixed at 4 in this revision.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_data, input, DATA_W bits: the word to route.
REQ-006 SHALL have port in_sel, input, 2 bits: the destination channel index.
REQ-007 SHALL have port in_valid, input, 1 bit: the source offers in_data/in_sel.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts this cycle.
REQ-009 SHALL have ports out_data0..out_data3, output, DATA_W bits each: the per-channel held word.
REQ-010 SHALL have ports out_valid0..out_valid3, output, 1 bit each: the channel slot holds a word.
REQ-011 SHALL have ports out_ready0..out_ready3, input, 1 bit each: the channel consumer takes the word.
REQ-012 SHALL have port xfer_count, output, 16 bits: the number of accepted input words.
REQ-013 SHALL have port busy, output, 1 bit: OR of all out_validN.

Function
REQ-014 An input transfer SHALL occur when in_valid && in_ready at a rising clk edge; an output transfer on channel N SHALL occur when out_validN && out_readyN at a rising clk edge.
REQ-015 Each channel SHALL have a one-entry slot with states EMPTY (out_validN=0) and FULL (out_validN=1).
REQ-016 in_ready SHALL be combinational: slot[in_sel] EMPTY, or slot[in_sel] FULL with out_ready[in_sel]=1; it SHALL NOT depend on in_valid.
REQ-017 An accepted word SHALL appear on out_data[in_sel] with out_valid[in_sel]=1 exactly one cycle after acceptance; latency is 1 cycle and there is no combinational in-to-out path.
REQ-018 Slot transitions: EMPTY->FULL on input transfer to N; FULL->EMPTY on output transfer with no input to N; FULL->FULL with new data on simultaneous output and input transfer to N; otherwise the slot holds.
REQ-019 out_dataN SHALL stay stable while out_validN=1 and out_readyN=0.
REQ-020 Input to channel N SHALL NOT disturb any other channel's slot; channels drain independently and concurrently.
REQ-021 in_sel/in_data SHALL be ignored when in_valid=0.
REQ-022 A full slot with its consumer stalled SHALL back-pressure only inputs addressed to that channel.
REQ-023 xfer_count SHALL increment by 1 per input transfer and wrap from 0xFFFF to 0x0000 without a flag.
REQ-024 out_dataN SHALL retain its last value after the slot empties.

Reset
REQ-025 While rst_n=0: out_valid0..3=0, out_data0..3=0, xfer_count=0, busy=0; in_ready SHALL then follow REQ-016 (1 with all slots EMPTY).
REQ-026 Reset asserted mid-operation SHALL discard held words immediately without waiting for clk; no transfer completes at the reset edge.
REQ-027 The first transfer SHALL be possible at the first rising clk edge after rst_n deasserts.

Structure
REQ-028 DATA_W default, channel count, and the 2-bit channel-select type SHALL live in the shared package fdt16_pkg.
REQ-029 The per-channel slot (valid/data register plus load/drain logic) SHALL be the sub-module chan_slot, instantiated 4 times.
REQ-030 in_ready generation, the select decode, and xfer_count SHALL reside in result_demux.

Verification
REQ-031 Drive in_data=0x1234, in_sel=2, in_valid=1 for one cycle with all out_ready=0 -> next cycle out_valid2=1, out_data2=0x1234, other valids 0, xfer_count=1.
REQ-032 With slot 2 full, out_ready2=0, drive in_sel=2 -> in_ready=0 and the word is not taken; drive in_sel=0 -> in_ready=1, and out_data0 updates the next cycle.
REQ-033 With slot 1 full holding 0xAAAA and out_ready1=1, drive in_sel=1, in_data=0x5555 -> in_ready=1; next cycle out_valid1=1 and out_data1=0x5555.
REQ-034 Preload xfer_count to 0xFFFF via 65535 transfers, then one more transfer -> xfer_count=0x0000.
REQ-035 Fill all four slots, then pulse rst_n low between clock edges -> all out_valid=0, out_data=0, busy=0 immediately, and in_ready=1.
REQ-036 Randomised in_sel/in_valid/out_readyN for 10k cycles against a per-channel FIFO-of-one model -> no loss, no duplication, order preserved per channel.
